mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle ARM control unit, directly upstream of the datapath. It sequences each instruction through a main FSM.
//  It decodes Instr[31:12] into mux selects and ALUControl, and holds the NZCV flag registers.
//  It applies condition-code gating to PCWrite, RegWrite and MemWrite.
// PARAMETERS
//  HALT_ON_UNKNOWN  0  1: UNKNOWN is terminal until reset; 0: UNKNOWN returns to FETCH next cycle
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  asynchronous, active-low reset (0 = in reset)
//  Instr       in  20  Instr[31:12] from IR: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
//  ALUFlags    in   4  {N,Z,C,V} from datapath ALU, same cycle
//  PCWrite     out  1  PC register enable
//  MemWrite    out  1  memory write strobe
//  RegWrite    out  1  register file write enable
//  IRWrite     out  1  instruction register enable
//  AdrSrc      out  1  0=PC, 1=Result to memory address
//  RegSrc      out  2  [0]=1 RA1=R15 (branch); [1]=1 RA2=Rd (store)
//  ALUSrcA     out  2  00=A, 01=PC, 10=ALUOut
//  ALUSrcB     out  2  00=WriteData, 01=ExtImm, 10=constant 4
//  ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ImmSrc      out  2  equals Op
//  ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
//  state       out  4  current FSM state encoding, for verification
// BEHAVIOUR
//  - States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
//  - Transitions: FETCH->DECODE.
//    DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECR, Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->UNKNOWN.
//    MEMADR: Funct[0]=1->MEMREAD, else MEMWRITE. MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH.
//    EXECR and EXECI->ALUWB->FETCH. BRANCH->FETCH.
//  - Per-state outputs; unlisted outputs are 0 and ALUOp=0 unless stated:
//    FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
//    DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
//    MEMADR: ALUSrcA=00, ALUSrcB=01.
//    MEMREAD: AdrSrc=1, ResultSrc=00.  MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
//    MEMWB: ResultSrc=01, RegW=1.  ALUWB: ResultSrc=00, RegW=1.
//    EXECR: ALUSrcA=00, ALUSrcB=00, ALUOp=1.  EXECI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
//    BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1.  UNKNOWN: all enables 0.
//  - ALU decode: ALUOp=0 -> ALUControl=00, FlagW=00.
//    ALUOp=1 decodes Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, others ADD.
//    FlagW[1]=Funct[0] (updates NZ). FlagW[0]=Funct[0] and (ADD or SUB) (updates CV).
//  - RegSrc/ImmSrc are combinational from Op in every state.
//  - Condition: CondEx from Cond and stored flags per the ARM table (0000 EQ ... 1101 LE); 1110 AL=1; 1111=0.
//  - Flags: {N,Z} loads ALUFlags[3:2] on the clk edge when FlagW[1]&CondEx. {C,V} loads ALUFlags[1:0] when FlagW[0]&CondEx.
//  - CondExD: flop loads CondEx every cycle; it holds the value from the previous state.
//  - Gating: PCS=(Rd==4'hF & RegW) | Branch. PCWrite=NextPC | (PCS & CondExD). RegWrite=RegW & CondExD. MemWrite=MemW & CondExD.
//  - Flag update in EXEC uses pre-update flags for CondEx; ALUWB uses CondExD, which is unaffected by that same update.
//  - Latency in cycles: branch 3, data-processing 4, STR 4, LDR 5.
//  - Reset (reset=0, asynchronous): state=FETCH, flags=0000, CondExD=0.
//    While reset=0, PCWrite, IRWrite, RegWrite and MemWrite are forced 0; mux selects show FETCH values.
//    Reset asserted mid-instruction aborts it and performs no write. First FETCH is the first cycle after reset deasserts.
// TESTING
//  - Release reset, Instr=ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000):
//    states 0,1,6,8,0; RegWrite=1 only in ALUWB; ALUControl=00 in EXECR.
//  - LDR (Op=01, Funct[0]=1): states 0,1,2,3,4,0; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB.
//  - STR with Cond=0000, Z=0: states 0,1,2,5,0; MemWrite=0. Repeat with Z=1: MemWrite=1 in MEMWRITE.
//  - SUBS (Funct=000101) with ALUFlags=0100, then BEQ (Cond=0000, Op=10): PCWrite=1 in BRANCH.
//    BNE (Cond=0001): PCWrite=0.
//  - ADD with Rd=15, Cond=AL: PCWrite=1 and RegWrite=1 in ALUWB.
//  - Assert reset=0 while in MEMADR: state=0 immediately, with no clk edge; all enables 0 until release.
//  - Op=11: DECODE->UNKNOWN. HALT_ON_UNKNOWN=0 -> FETCH next cycle; HALT_ON_UNKNOWN=1 -> stays in UNKNOWN.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: main sequencing FSM, ALU decode, NZCV flag storage
// and condition-code gating of the architectural write enables.
module mc_controller #(
    parameter bit HALT_ON_UNKNOWN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  state
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_e;

    typedef struct packed {
        logic       next_pc;
        logic       branch;
        logic       reg_w;
        logic       mem_w;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
    } ctrl_t;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    // Per-state control word, before condition gating.
    function automatic ctrl_t ctrl_for(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.ir_write   = 1'b1;
                c.next_pc    = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_MEMADR:   c.alu_src_b = 2'b01;
            S_MEMREAD:  c.adr_src   = 1'b1;
            S_MEMWRITE: begin
                c.adr_src = 1'b1;
                c.mem_w   = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_w      = 1'b1;
            end
            S_ALUWB:    c.reg_w  = 1'b1;
            S_EXECR:    c.alu_op = 1'b1;
            S_EXECI: begin
                c.alu_src_b = 2'b01;
                c.alu_op    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_e     state_q, state_d;
    ctrl_t      ctrl_q;
    logic [3:0] flags_q;
    logic       cond_ex_q;
    logic       cond_ex;
    logic [1:0] flag_w;
    logic       pcs;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_MEMWB,
            S_MEMWRITE,
            S_ALUWB,
            S_BRANCH:   state_d = S_FETCH;
            S_UNKNOWN:  state_d = HALT_ON_UNKNOWN ? S_UNKNOWN : S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_for(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d);
        end
    end

    always_comb begin
        ALUControl = 2'b00;
        flag_w     = 2'b00;
        if (ctrl_q.alu_op) begin
            case (funct[4:1])
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                default: ALUControl = 2'b00;
            endcase
            flag_w[1] = funct[0];
            flag_w[0] = funct[0] & ~ALUControl[1];
        end
    end

    // flags_q = {N, Z, C, V}
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~(flags_q[1] & ~flags_q[2]);
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = ~(~flags_q[2] & (flags_q[3] == flags_q[0]));
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            cond_ex_q <= cond_ex;
            if (flag_w[1] & cond_ex) flags_q[3:2] <= ALUFlags[3:2];
            if (flag_w[0] & cond_ex) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Enables are held low for the whole time reset is asserted.
    assign pcs       = ((rd == 4'hF) & ctrl_q.reg_w) | ctrl_q.branch;
    assign PCWrite   = reset & (ctrl_q.next_pc | (pcs & cond_ex_q));
    assign RegWrite  = reset & ctrl_q.reg_w & cond_ex_q;
    assign MemWrite  = reset & ctrl_q.mem_w & cond_ex_q;
    assign IRWrite   = reset & ctrl_q.ir_write;
    assign AdrSrc    = ctrl_q.adr_src;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign ResultSrc = ctrl_q.result_src;
    assign RegSrc    = {op == 2'b01, op == 2'b10};
    assign ImmSrc    = op;
    assign state     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: instruction walks, condition gating, reset abort,
// and both UNKNOWN-opcode behaviours.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0]  state;

    logic        PCWrite_h, MemWrite_h, RegWrite_h, IRWrite_h, AdrSrc_h;
    logic [1:0]  RegSrc_h, ALUSrcA_h, ALUSrcB_h, ResultSrc_h, ImmSrc_h, ALUControl_h;
    logic [3:0]  state_h;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_controller #(.HALT_ON_UNKNOWN(1'b0)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state(state)
    );

    mc_controller #(.HALT_ON_UNKNOWN(1'b1)) dut_halt (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite_h), .MemWrite(MemWrite_h), .RegWrite(RegWrite_h), .IRWrite(IRWrite_h),
        .AdrSrc(AdrSrc_h), .RegSrc(RegSrc_h), .ALUSrcA(ALUSrcA_h), .ALUSrcB(ALUSrcB_h),
        .ResultSrc(ResultSrc_h), .ImmSrc(ImmSrc_h), .ALUControl(ALUControl_h), .state(state_h)
    );

    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_NE = 4'b0001;
    localparam logic [3:0] C_AL = 4'b1110;

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] o,
                                       input logic [5:0] f, input logic [3:0] d);
        return {c, o, f, 4'h0, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int exp_st, input string tag);
        tick();
        check(tag, 32'(state), 32'(exp_st));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        ALUFlags = 4'b0000;
        Instr    = mk(C_AL, 2'b00, 6'b001000, 4'd1);
        tick();
        tick();
        check("rst state",     32'(state),     0);
        check("rst pcwrite",   32'(PCWrite),   0);
        check("rst irwrite",   32'(IRWrite),   0);
        check("rst regwrite",  32'(RegWrite),  0);
        check("rst memwrite",  32'(MemWrite),  0);
        check("rst alusrca",   32'(ALUSrcA),   1);
        check("rst alusrcb",   32'(ALUSrcB),   2);
        check("rst resultsrc", 32'(ResultSrc), 2);

        reset = 1'b1;
        #1;
        check("fetch state",   32'(state),   0);
        check("fetch irwrite", 32'(IRWrite), 1);
        check("fetch pcwrite", 32'(PCWrite), 1);
        check("fetch adrsrc",  32'(AdrSrc),  0);

        // ADD R1,R2,R3
        step(1, "add decode");
        step(6, "add execr");
        check("add aluctl",   32'(ALUControl), 0);
        check("add execr rw", 32'(RegWrite),   0);
        check("add alusrcb",  32'(ALUSrcB),    0);
        step(8, "add aluwb");
        check("add aluwb rw", 32'(RegWrite),  1);
        check("add aluwb pc", 32'(PCWrite),   0);
        check("add aluwb rs", 32'(ResultSrc), 0);
        step(0, "add done");
        check("add fetch rw", 32'(RegWrite), 0);

        // LDR
        Instr = mk(C_AL, 2'b01, 6'b011001, 4'd2);
        step(1, "ldr decode");
        check("ldr regsrc", 32'(RegSrc), 2);
        check("ldr immsrc", 32'(ImmSrc), 1);
        step(2, "ldr memadr");
        check("ldr memadr srcb", 32'(ALUSrcB), 1);
        step(3, "ldr memread");
        check("ldr adrsrc", 32'(AdrSrc), 1);
        step(4, "ldr memwb");
        check("ldr memwb rs", 32'(ResultSrc), 1);
        check("ldr memwb rw", 32'(RegWrite),  1);
        step(0, "ldr done");

        // STREQ with Z=0
        Instr = mk(C_EQ, 2'b01, 6'b011000, 4'd3);
        step(1, "streq0 decode");
        step(2, "streq0 memadr");
        step(5, "streq0 memwrite");
        check("streq0 memwrite", 32'(MemWrite), 0);
        check("streq0 adrsrc",   32'(AdrSrc),   1);
        step(0, "streq0 done");

        // SUBS producing Z=1
        Instr = mk(C_AL, 2'b00, 6'b000101, 4'd4);
        step(1, "subs decode");
        ALUFlags = 4'b0100;
        step(6, "subs execr");
        check("subs aluctl", 32'(ALUControl), 1);
        step(8, "subs aluwb");
        check("subs rw", 32'(RegWrite), 1);
        ALUFlags = 4'b0000;
        step(0, "subs done");

        // STREQ with Z=1
        Instr = mk(C_EQ, 2'b01, 6'b011000, 4'd3);
        step(1, "streq1 decode");
        step(2, "streq1 memadr");
        step(5, "streq1 memwrite");
        check("streq1 memwrite", 32'(MemWrite), 1);
        step(0, "streq1 done");
        check("streq1 fetch mw", 32'(MemWrite), 0);

        // BEQ taken
        Instr = mk(C_EQ, 2'b10, 6'b000000, 4'd0);
        step(1, "beq decode");
        check("beq regsrc", 32'(RegSrc), 1);
        step(9, "beq branch");
        check("beq pcwrite", 32'(PCWrite), 1);
        step(0, "beq done");

        // BNE not taken
        Instr = mk(C_NE, 2'b10, 6'b000000, 4'd0);
        step(1, "bne decode");
        step(9, "bne branch");
        check("bne pcwrite", 32'(PCWrite), 0);
        step(0, "bne done");

        // ADD to PC
        Instr = mk(C_AL, 2'b00, 6'b001000, 4'd15);
        step(1, "addpc decode");
        step(6, "addpc execr");
        step(8, "addpc aluwb");
        check("addpc pcwrite",  32'(PCWrite),  1);
        check("addpc regwrite", 32'(RegWrite), 1);
        step(0, "addpc done");

        // ORR immediate
        Instr = mk(C_AL, 2'b00, 6'b111000, 4'd5);
        step(1, "orr decode");
        step(7, "orr execi");
        check("orr aluctl",  32'(ALUControl), 3);
        check("orr alusrcb", 32'(ALUSrcB),    1);
        step(8, "orr aluwb");
        step(0, "orr done");

        // Reset asserted in MEMADR
        Instr = mk(C_AL, 2'b01, 6'b011001, 4'd2);
        step(1, "abort decode");
        step(2, "abort memadr");
        reset = 1'b0;
        #1;
        check("abort state",    32'(state),    0);
        check("abort pcwrite",  32'(PCWrite),  0);
        check("abort irwrite",  32'(IRWrite),  0);
        check("abort regwrite", 32'(RegWrite), 0);
        check("abort adrsrc",   32'(AdrSrc),   0);
        check("abort alusrcb",  32'(ALUSrcB),  2);
        tick();
        check("abort hold state", 32'(state),    0);
        check("abort hold pc",    32'(PCWrite),  0);
        check("abort hold rw",    32'(RegWrite), 0);
        reset = 1'b1;
        #1;
        check("release irwrite", 32'(IRWrite), 1);

        // Reset cleared Z, so BEQ is not taken
        Instr = mk(C_EQ, 2'b10, 6'b000000, 4'd0);
        step(1, "beq2 decode");
        step(9, "beq2 branch");
        check("beq2 pcwrite", 32'(PCWrite), 0);
        step(0, "beq2 done");

        // Undefined opcode, both halt settings
        Instr = mk(C_AL, 2'b11, 6'b000000, 4'd0);
        step(1, "unk decode");
        step(10, "unk state");
        check("unk halt state", 32'(state_h), 10);
        check("unk pcwrite",    32'(PCWrite), 0);
        check("unk irwrite",    32'(IRWrite), 0);
        step(0, "unk return");
        check("unk halt stays",   32'(state_h),   10);
        check("unk halt irwrite", 32'(IRWrite_h), 0);
        step(1, "unk redecode");
        check("unk halt stays2", 32'(state_h), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
